// File: rtl/mem_responder.sv
// Memory-side responder: 2**ADDR_W x DATA_W synchronous RAM with single-cycle
// write/read service, per-word written tracking, collision and uninitialised-read
// pulses, and saturating access counters.
module mem_responder #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              err_coll,
  output logic              err_uninit,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  rd_count
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [1:0] {ReqIdle, ReqWrite, ReqRead, ReqColl} req_e;

  req_e              req;
  logic [DATA_W-1:0] mem_q [Depth];
  logic [Depth-1:0]  written_q, written_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              rd_valid_q, rd_valid_d;
  logic              err_coll_q, err_coll_d;
  logic              err_uninit_q, err_uninit_d;
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;
  logic [CNT_W-1:0]  rd_count_q, rd_count_d;

  // Request decode; an X/Z on read or write falls through to idle.
  always_comb begin
    req = ReqIdle;
    if (read == 1'b1 && write == 1'b1) begin
      req = ReqColl;
    end else if (read == 1'b1 && write == 1'b0) begin
      req = ReqRead;
    end else if (write == 1'b1 && read == 1'b0) begin
      req = ReqWrite;
    end
  end

  // Next-state for read data, pulses, tracking bits and saturating counters.
  always_comb begin
    data_out_d   = data_out_q;
    rd_valid_d   = 1'b0;
    err_coll_d   = 1'b0;
    err_uninit_d = 1'b0;
    written_d    = written_q;
    wr_count_d   = wr_count_q;
    rd_count_d   = rd_count_q;
    unique case (req)
      ReqWrite: begin
        written_d[addr] = 1'b1;
        if (wr_count_q != '1) wr_count_d = wr_count_q + CNT_W'(1);
      end
      ReqRead: begin
        data_out_d   = mem_q[addr];
        rd_valid_d   = 1'b1;
        err_uninit_d = ~written_q[addr];
        if (rd_count_q != '1) rd_count_d = rd_count_q + CNT_W'(1);
      end
      ReqColl: err_coll_d = 1'b1;
      default: ;
    endcase
  end

  // Control/status registers; reset drops any request in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out_q   <= '0;
      rd_valid_q   <= 1'b0;
      err_coll_q   <= 1'b0;
      err_uninit_q <= 1'b0;
      written_q    <= '0;
      wr_count_q   <= '0;
      rd_count_q   <= '0;
    end else begin
      data_out_q   <= data_out_d;
      rd_valid_q   <= rd_valid_d;
      err_coll_q   <= err_coll_d;
      err_uninit_q <= err_uninit_d;
      written_q    <= written_d;
      wr_count_q   <= wr_count_d;
      rd_count_q   <= rd_count_d;
    end
  end

  // RAM array: contents survive reset, only the write is gated by it.
  always_ff @(posedge clk) begin
    if (rst_n && req == ReqWrite) begin
      mem_q[addr] <= data_in;
    end
  end

  assign data_out   = data_out_q;
  assign rd_valid   = rd_valid_q;
  assign err_coll   = err_coll_q;
  assign err_uninit = err_uninit_q;
  assign wr_count   = wr_count_q;
  assign rd_count   = rd_count_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: scoreboard of expected read results,
// reference RAM model, and a narrow-counter instance for saturation checks.
module tb_mem_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       read, write;
  logic [4:0] addr;
  logic [7:0] data_in;

  logic [7:0]  data_out, data_out_s;
  logic        rd_valid, rd_valid_s, err_coll, err_coll_s, err_uninit, err_uninit_s;
  logic [15:0] wr_count, rd_count;
  logic [3:0]  wr_count_s, rd_count_s;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(5), .DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr),
    .data_in(data_in), .data_out(data_out), .rd_valid(rd_valid), .err_coll(err_coll),
    .err_uninit(err_uninit), .wr_count(wr_count), .rd_count(rd_count)
  );

  mem_responder #(.ADDR_W(5), .DATA_W(8), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr),
    .data_in(data_in), .data_out(data_out_s), .rd_valid(rd_valid_s),
    .err_coll(err_coll_s), .err_uninit(err_uninit_s), .wr_count(wr_count_s),
    .rd_count(rd_count_s)
  );

  typedef struct {
    logic [7:0] data;
    logic       data_known;
    logic       uninit;
  } rd_exp_t;

  rd_exp_t    rd_q[$];
  logic [7:0] m_data [32];
  logic       m_known [32];
  logic       m_written [32];
  logic [7:0] m_out;
  logic       m_out_known;
  int         m_wr, m_rd;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  // One bus cycle: drive on negedge, update model, check #1 after posedge.
  task automatic op(input logic rst, input logic r, input logic w,
                    input logic [4:0] a, input logic [7:0] d);
    rd_exp_t e;
    logic    exp_rd, exp_coll;
    @(negedge clk);
    rst_n = ~rst; read = r; write = w; addr = a; data_in = d;
    exp_rd   = !rst && r && !w;
    exp_coll = !rst && r && w;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_written[i] = 1'b0;
      m_wr = 0; m_rd = 0; m_out = 8'h00; m_out_known = 1'b1;
    end else if (exp_rd) begin
      e.data = m_data[a]; e.data_known = m_known[a]; e.uninit = !m_written[a];
      rd_q.push_back(e);
      m_rd++;
    end else if (w && !r) begin
      m_data[a] = d; m_known[a] = 1'b1; m_written[a] = 1'b1;
      m_wr++;
    end
    @(posedge clk);
    #1;
    check("rd_valid", {31'b0, rd_valid}, {31'b0, exp_rd});
    check("err_coll", {31'b0, err_coll}, {31'b0, exp_coll});
    if (rd_valid) begin
      if (rd_q.size() == 0) begin
        check("rd_unexpected", 32'd1, 32'd0);
      end else begin
        e = rd_q.pop_front();
        check("err_uninit", {31'b0, err_uninit}, {31'b0, e.uninit});
        m_out = data_out;
        m_out_known = e.data_known;
        if (e.data_known) check("rd_data", {24'b0, data_out}, {24'b0, e.data});
      end
    end else begin
      check("err_uninit_idle", {31'b0, err_uninit}, 32'd0);
      if (m_out_known) check("data_hold", {24'b0, data_out}, {24'b0, m_out});
    end
    if (exp_rd && rd_q.size() != 0) check("rd_missing", 32'd1, 32'd0);
    check("wr_count", {16'b0, wr_count}, sat(m_wr, 65535));
    check("rd_count", {16'b0, rd_count}, sat(m_rd, 65535));
    check("wr_count_sat", {28'b0, wr_count_s}, sat(m_wr, 15));
    check("rd_count_sat", {28'b0, rd_count_s}, sat(m_rd, 15));
    check("sat_rd_valid", {31'b0, rd_valid_s}, {31'b0, exp_rd});
  endtask

  initial begin
    rst_n = 1'b0; read = 1'b0; write = 1'b0; addr = '0; data_in = '0;
    m_wr = 0; m_rd = 0; m_out = 8'h00; m_out_known = 1'b1;
    for (int i = 0; i < 32; i++) begin
      m_data[i] = 8'h00; m_known[i] = 1'b0; m_written[i] = 1'b0;
    end

    // Reset state, then zero-fill and read back.
    op(1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
    op(1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
    for (int i = 0; i < 32; i++) op(1'b0, 1'b0, 1'b1, 5'(i), 8'h00);
    for (int i = 0; i < 32; i++) op(1'b0, 1'b1, 1'b0, 5'(i), 8'h00);
    check("t1_wr_count", {16'b0, wr_count}, 32'd32);
    check("t1_rd_count", {16'b0, rd_count}, 32'd32);

    // Address-as-data pattern, back-to-back reads, write-then-read.
    for (int i = 0; i < 32; i++) op(1'b0, 1'b0, 1'b1, 5'(i), 8'(i));
    for (int i = 0; i < 32; i++) op(1'b0, 1'b1, 1'b0, 5'(i), 8'h00);
    op(1'b0, 1'b0, 1'b1, 5'd5, 8'hA5);
    op(1'b0, 1'b1, 1'b0, 5'd5, 8'h00);
    check("t2_a5", {24'b0, data_out}, 32'hA5);

    // Uninitialised read after reset, then write/read.
    op(1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
    op(1'b0, 1'b1, 1'b0, 5'd7, 8'h00);
    check("t3_uninit", {31'b0, err_uninit}, 32'd1);
    op(1'b0, 1'b0, 1'b1, 5'd7, 8'h3C);
    op(1'b0, 1'b1, 1'b0, 5'd7, 8'h00);
    check("t3_3c", {24'b0, data_out}, 32'h3C);

    // Collision leaves RAM and counters alone.
    op(1'b0, 1'b0, 1'b1, 5'd2, 8'h11);
    op(1'b0, 1'b1, 1'b1, 5'd2, 8'hFF);
    op(1'b0, 1'b0, 1'b0, 5'd2, 8'h00);
    op(1'b0, 1'b1, 1'b0, 5'd2, 8'h00);
    check("t4_11", {24'b0, data_out}, 32'h11);

    // Reset mid write stream to addr 9 drops that write.
    op(1'b0, 1'b0, 1'b1, 5'd9, 8'h55);
    op(1'b1, 1'b0, 1'b1, 5'd9, 8'h66);
    op(1'b0, 1'b1, 1'b0, 5'd9, 8'h00);
    check("t5_kept", {24'b0, data_out}, 32'h55);
    op(1'b0, 1'b0, 1'b1, 5'd9, 8'h77);
    op(1'b0, 1'b1, 1'b0, 5'd9, 8'h00);
    check("t5_new", {24'b0, data_out}, 32'h77);

    // Saturation: 20 writes push the 4-bit counter past its limit.
    op(1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
    for (int i = 0; i < 20; i++) op(1'b0, 1'b0, 1'b1, 5'(i), 8'($urandom_range(255)));
    check("t6_sat", {28'b0, wr_count_s}, 32'hF);
    for (int i = 0; i < 20; i++) op(1'b0, 1'b1, 1'b0, 5'(i), 8'h00);
    for (int i = 0; i < 10; i++)
      op(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 5'($urandom_range(31)),
         8'($urandom_range(255)));

    op(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    check("queue_empty", rd_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
